// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset constants and buffer entry type for the fetch stage
package fetch_unit_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 32'h0000_0013;
  typedef logic [$clog2(FETCH_BUF_DEPTH+1)-1:0] buf_cnt_t;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic is_aligned(input logic [ADDR_W-1:0] a);
    return a[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction read port between the fetch stage and the bus
interface fetch_unit_if;
  import fetch_unit_pkg::*;
  logic instr_rd_en_o;
  logic [ADDR_W-1:0] addr_instr_o;
  logic [INSTR_W-1:0] data_instr_i;
  logic [ADDR_W-1:0] addr_instr_i;
  modport master (output instr_rd_en_o, addr_instr_o, input data_instr_i, addr_instr_i);
  modport slave (input instr_rd_en_o, addr_instr_o, output data_instr_i, addr_instr_i);
endinterface

// File: rtl/fetch_unit_buf.sv
// fetch_unit_buf: 2-entry {pc, instr} FIFO with synchronous flush; entry 0 is always the head
module fetch_unit_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output buf_cnt_t     count_o
);
  fetch_entry_t e0_q, e1_q;
  buf_cnt_t cnt_q, lvl;
  always_comb lvl = cnt_q - buf_cnt_t'(pop_i);
  // pop shifts first, then push lands in the slot left free after the pop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      e0_q <= '0;
      e1_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      if (pop_i) e0_q <= e1_q;
      if (push_i && lvl == buf_cnt_t'(0)) e0_q <= din_i;
      if (push_i && lvl == buf_cnt_t'(1)) e1_q <= din_i;
      cnt_q <= lvl + buf_cnt_t'(push_i);
    end
  end
  assign head_o = e0_q;
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, bus instruction requests, redirect/misalignment handling and
// a 2-entry return buffer presenting {pc, instr} to decode
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       bus,
  input  logic               stall_i,
  input  logic               jump_en_i,
  input  logic [ADDR_W-1:0]  jump_addr_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               instr_valid_o,
  output logic               fetch_err_o
);
  logic [ADDR_W-1:0] pc_q, pc_d, err_pc_q, err_pc_d, addr;
  logic inflight_q, err_q, err_d, rd_en, jmp_ok, valid, pop, push;
  logic [2:0] need;
  buf_cnt_t cnt;
  fetch_entry_t head, din;
  // responses are trusted only one cycle after a request; a jump discards them
  always_comb begin
    jmp_ok = jump_en_i && is_aligned(jump_addr_i);
    valid = (cnt != '0) && !err_q;
    pop = valid && !stall_i;
    push = inflight_q && !jump_en_i;
    need = 3'(cnt) + 3'(inflight_q) - 3'(pop);
    rd_en = !rst && (jump_en_i ? jmp_ok : (!err_q && need <= 3'd1));
    addr = jump_en_i ? jump_addr_i : pc_q;
    pc_d = rd_en ? addr + ADDR_W'(4) : pc_q;
    err_d = jump_en_i ? !jmp_ok : err_q;
    err_pc_d = jump_en_i ? jump_addr_i : err_pc_q;
    din = '{pc: bus.addr_instr_i, instr: bus.data_instr_i};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      err_q <= 1'b0;
      err_pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= rd_en;
      err_q <= err_d;
      err_pc_q <= err_pc_d;
    end
  end
  fetch_unit_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (jump_en_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .count_o (cnt)
  );
  assign bus.instr_rd_en_o = rd_en;
  assign bus.addr_instr_o = addr;
  assign instr_valid_o = valid;
  assign instr_o = valid ? head.instr : NOP_INSTR;
  assign pc_o = err_q ? err_pc_q : head.pc;
  assign fetch_err_o = err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios against a 1-cycle bus model holding 0xC0000000|k at address 4k
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk, rst, stall, jmp;
  logic [31:0] jaddr, instr, pc;
  logic valid, err;
  int checks = 0, errors = 0;
  fetch_unit_if bus();
  fetch_unit dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_i(stall), .jump_en_i(jmp), .jump_addr_i(jaddr),
    .instr_o(instr), .pc_o(pc), .instr_valid_o(valid), .fetch_err_o(err)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC000_0000 | (a >> 2);
  endfunction
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk)
    if (bus.instr_rd_en_o) begin
      bus.data_instr_i <= mem(bus.addr_instr_o);
      bus.addr_instr_i <= bus.addr_instr_o;
    end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; jmp = 1'b0; jaddr = '0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (bus.instr_rd_en_o !== 1'b0) begin errors++; $display("FAIL reset rd_en got %0b exp 0", bus.instr_rd_en_o); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset valid got %0b exp 0", valid); end
    checks++; if (instr !== NOP) begin errors++; $display("FAIL reset instr got %h exp %h", instr, NOP); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset pc got %h exp 0", pc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err got %0b exp 0", err); end
    step();
  endtask
  task automatic test_stream;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (bus.instr_rd_en_o !== 1'b1) begin errors++; $display("FAIL stream c%0d rd_en got %0b exp 1", c, bus.instr_rd_en_o); end
      checks++; if (bus.addr_instr_o !== 32'(4*c)) begin errors++; $display("FAIL stream c%0d addr got %h exp %h", c, bus.addr_instr_o, 32'(4*c)); end
      checks++; if (valid !== (c >= 2)) begin errors++; $display("FAIL stream c%0d valid got %0b exp %0b", c, valid, c >= 2); end
      if (c >= 2) begin
        checks++; if (pc !== 32'(4*(c-2))) begin errors++; $display("FAIL stream c%0d pc got %h exp %h", c, pc, 32'(4*(c-2))); end
        checks++; if (instr !== mem(32'(4*(c-2)))) begin errors++; $display("FAIL stream c%0d instr got %h exp %h", c, instr, mem(32'(4*(c-2)))); end
      end else begin
        checks++; if (instr !== NOP) begin errors++; $display("FAIL stream c%0d instr got %h exp NOP", c, instr); end
      end
      step();
    end
  endtask
  task automatic test_stall;
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.instr_rd_en_o !== 1'b0) begin errors++; $display("FAIL stall c%0d rd_en got %0b exp 0", c, bus.instr_rd_en_o); end
      checks++; if (valid !== 1'b1 || pc !== 32'h18) begin errors++; $display("FAIL stall c%0d valid/pc got %0b/%h exp 1/18", c, valid, pc); end
      checks++; if (instr !== mem(32'h18)) begin errors++; $display("FAIL stall c%0d instr got %h exp %h", c, instr, mem(32'h18)); end
      step();
    end
    stall = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.instr_rd_en_o !== 1'b1 || bus.addr_instr_o !== 32'(32+4*c)) begin errors++; $display("FAIL resume c%0d rd_en/addr got %0b/%h exp 1/%h", c, bus.instr_rd_en_o, bus.addr_instr_o, 32'(32+4*c)); end
      checks++; if (valid !== 1'b1 || pc !== 32'(24+4*c)) begin errors++; $display("FAIL resume c%0d valid/pc got %0b/%h exp 1/%h", c, valid, pc, 32'(24+4*c)); end
      checks++; if (instr !== mem(32'(24+4*c))) begin errors++; $display("FAIL resume c%0d instr got %h exp %h", c, instr, mem(32'(24+4*c))); end
      step();
    end
  endtask
  task automatic test_jump;
    logic [4:0] st = 5'b00001, jp = 5'b00010, er = 5'b11110, ev = 5'b11011;
    logic [31:0] ea[5] = '{32'h0, 32'h40, 32'h44, 32'h48, 32'h4c};
    logic [31:0] ep[5] = '{32'h28, 32'h28, 32'h0, 32'h40, 32'h44};
    for (int c = 0; c < 5; c++) begin
      stall = st[c]; jmp = jp[c]; jaddr = 32'h40;
      @(negedge clk);
      checks++; if (bus.instr_rd_en_o !== er[c]) begin errors++; $display("FAIL jump c%0d rd_en got %0b exp %0b", c, bus.instr_rd_en_o, er[c]); end
      if (er[c]) begin checks++; if (bus.addr_instr_o !== ea[c]) begin errors++; $display("FAIL jump c%0d addr got %h exp %h", c, bus.addr_instr_o, ea[c]); end end
      checks++; if (valid !== ev[c]) begin errors++; $display("FAIL jump c%0d valid got %0b exp %0b", c, valid, ev[c]); end
      checks++; if (instr !== (ev[c] ? mem(ep[c]) : NOP)) begin errors++; $display("FAIL jump c%0d instr got %h exp %h", c, instr, ev[c] ? mem(ep[c]) : NOP); end
      if (ev[c]) begin checks++; if (pc !== ep[c]) begin errors++; $display("FAIL jump c%0d pc got %h exp %h", c, pc, ep[c]); end end
      step();
    end
    jmp = 1'b0; stall = 1'b0;
  endtask
  task automatic test_misaligned;
    logic [6:0] jp = 7'b0001001, er = 7'b1111000, ev = 7'b1100001, ee = 7'b0001110;
    logic [31:0] ep[7] = '{32'h48, 32'h0, 32'h0, 32'h0, 32'h0, 32'h80, 32'h84};
    for (int c = 0; c < 7; c++) begin
      jmp = jp[c]; jaddr = (c == 0) ? 32'h42 : 32'h80;
      @(negedge clk);
      checks++; if (bus.instr_rd_en_o !== er[c]) begin errors++; $display("FAIL misalign c%0d rd_en got %0b exp %0b", c, bus.instr_rd_en_o, er[c]); end
      if (er[c]) begin checks++; if (bus.addr_instr_o !== 32'(128+4*(c-3))) begin errors++; $display("FAIL misalign c%0d addr got %h exp %h", c, bus.addr_instr_o, 32'(128+4*(c-3))); end end
      checks++; if (err !== ee[c]) begin errors++; $display("FAIL misalign c%0d err got %0b exp %0b", c, err, ee[c]); end
      checks++; if (valid !== ev[c]) begin errors++; $display("FAIL misalign c%0d valid got %0b exp %0b", c, valid, ev[c]); end
      checks++; if (instr !== (ev[c] ? mem(ep[c]) : NOP)) begin errors++; $display("FAIL misalign c%0d instr got %h exp %h", c, instr, ev[c] ? mem(ep[c]) : NOP); end
      if (ee[c]) begin checks++; if (pc !== 32'h42) begin errors++; $display("FAIL misalign c%0d pc got %h exp 42", c, pc); end end
      else if (ev[c]) begin checks++; if (pc !== ep[c]) begin errors++; $display("FAIL misalign c%0d pc got %h exp %h", c, pc, ep[c]); end end
      step();
    end
    jmp = 1'b0;
  endtask
  task automatic test_jump_stall;
    logic [5:0] st = 6'b001111, jp = 6'b000001, er = 6'b110011, ev = 6'b111101;
    logic [31:0] ea[6] = '{32'h100, 32'h104, 32'h0, 32'h0, 32'h108, 32'h10c};
    logic [31:0] ep[6] = '{32'h88, 32'h0, 32'h100, 32'h100, 32'h100, 32'h104};
    for (int c = 0; c < 6; c++) begin
      stall = st[c]; jmp = jp[c]; jaddr = 32'h100;
      @(negedge clk);
      checks++; if (bus.instr_rd_en_o !== er[c]) begin errors++; $display("FAIL jstall c%0d rd_en got %0b exp %0b", c, bus.instr_rd_en_o, er[c]); end
      if (er[c]) begin checks++; if (bus.addr_instr_o !== ea[c]) begin errors++; $display("FAIL jstall c%0d addr got %h exp %h", c, bus.addr_instr_o, ea[c]); end end
      checks++; if (valid !== ev[c]) begin errors++; $display("FAIL jstall c%0d valid got %0b exp %0b", c, valid, ev[c]); end
      checks++; if (instr !== (ev[c] ? mem(ep[c]) : NOP)) begin errors++; $display("FAIL jstall c%0d instr got %h exp %h", c, instr, ev[c] ? mem(ep[c]) : NOP); end
      if (ev[c]) begin checks++; if (pc !== ep[c]) begin errors++; $display("FAIL jstall c%0d pc got %h exp %h", c, pc, ep[c]); end end
      step();
    end
    jmp = 1'b0; stall = 1'b0;
  endtask
  task automatic test_reset_inflight;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.instr_rd_en_o !== 1'b0) begin errors++; $display("FAIL rst_if rd_en got %0b exp 0", bus.instr_rd_en_o); end
    step();
    @(negedge clk);
    checks++; if (valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_if valid/err got %0b/%0b exp 0/0", valid, err); end
    checks++; if (instr !== NOP || pc !== 32'h0) begin errors++; $display("FAIL rst_if instr/pc got %h/%h exp %h/0", instr, pc, NOP); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (bus.instr_rd_en_o !== 1'b1 || bus.addr_instr_o !== 32'(4*c)) begin errors++; $display("FAIL rst_if c%0d rd_en/addr got %0b/%h exp 1/%h", c, bus.instr_rd_en_o, bus.addr_instr_o, 32'(4*c)); end
      checks++; if (valid !== (c == 2)) begin errors++; $display("FAIL rst_if c%0d valid got %0b exp %0b", c, valid, c == 2); end
      if (c == 2) begin checks++; if (pc !== 32'h0 || instr !== mem(32'h0)) begin errors++; $display("FAIL rst_if c%0d pc/instr got %h/%h exp 0/%h", c, pc, instr, mem(32'h0)); end end
      step();
    end
  endtask
  task automatic test_wrap;
    logic [3:0] jp = 4'b0001, ev = 4'b1101;
    logic [31:0] ea[4] = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    logic [31:0] ep[4] = '{32'h4, 32'h0, 32'hFFFF_FFFC, 32'h0};
    for (int c = 0; c < 4; c++) begin
      jmp = jp[c]; jaddr = 32'hFFFF_FFFC;
      @(negedge clk);
      checks++; if (bus.instr_rd_en_o !== 1'b1 || bus.addr_instr_o !== ea[c]) begin errors++; $display("FAIL wrap c%0d rd_en/addr got %0b/%h exp 1/%h", c, bus.instr_rd_en_o, bus.addr_instr_o, ea[c]); end
      checks++; if (valid !== ev[c]) begin errors++; $display("FAIL wrap c%0d valid got %0b exp %0b", c, valid, ev[c]); end
      if (ev[c]) begin checks++; if (pc !== ep[c] || instr !== mem(ep[c])) begin errors++; $display("FAIL wrap c%0d pc/instr got %h/%h exp %h/%h", c, pc, instr, ep[c], mem(ep[c])); end end
      step();
    end
    jmp = 1'b0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_jump();
    test_misaligned();
    test_jump_stall();
    test_reset_inflight();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
